// File: rtl/dc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// dc_fifo_pkg
//   Definitions shared by the write controller and the buffer-side modules of
//   the dual-clock token-ring FIFO.
//   - log2  : ceiling log2, used to size binary slot indices and level outputs.
//   - rotl1 : rotate a one-hot pointer left by one slot inside a ring of
//             'depth' slots (bit depth-1 wraps to bit 0). Pointers are carried
//             zero-extended to PTR_MAX bits so one function serves every depth.
// -----------------------------------------------------------------------------
package dc_fifo_pkg;

   // Widest one-hot ring supported by rotl1.
   localparam int PTR_MAX = 64;

   function automatic int log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

   // Bits at or above 'depth' are outside the ring and come back as zero.
   function automatic logic [PTR_MAX-1:0] rotl1(input logic [PTR_MAX-1:0] vec,
                                                input int depth);
      logic [PTR_MAX-1:0] result;
      result = '0;
      for (int i = 0; i < PTR_MAX; i++) begin
         if (i == 0) begin
            result[i] = vec[depth-1];
         end else if (i < depth) begin
            result[i] = vec[i-1];
         end else begin
            result[i] = 1'b0;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/dc_onehot_to_bin.sv
// -----------------------------------------------------------------------------
// dc_onehot_to_bin
//   OR-reduction one-hot to binary encoder: output bit b is the OR of every
//   input bit whose index has bit b set. A non-one-hot input yields the OR of
//   the indices of its set bits (no priority logic).
// Ports
//   onehot  in   WIDTH       one-hot slot vector
//   bin     out  BIN_WIDTH   binary index of the set bit
// -----------------------------------------------------------------------------
module dc_onehot_to_bin
   import dc_fifo_pkg::*;
#(
   parameter  int WIDTH     = 8,
   localparam int BIN_WIDTH = log2(WIDTH)
) (
   input  logic [WIDTH-1:0]     onehot,
   output logic [BIN_WIDTH-1:0] bin
);

   // Encode: each output bit collects the slots whose index contains that bit.
   always_comb begin
      bin = '0;
      for (int b = 0; b < BIN_WIDTH; b++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i[b]) begin
               bin[b] = bin[b] | onehot[i];
            end else begin
               bin[b] = bin[b];
            end
         end
      end
   end

endmodule

// File: rtl/dc_fifo_write_ctrl.sv
// -----------------------------------------------------------------------------
// dc_fifo_write_ctrl
//   Write-side controller of the dual-clock token-ring FIFO, directly upstream
//   of dc_data_buffer. The write pointer is one-hot and advances by one slot on
//   every accepted beat. One slot is always left empty, so wp == rp means empty
//   and "next wp == rp" means full.
//
//   Optional build macro: DC_WR_SYNC_EN
//     defined   : read_pointer is passed through a 2-flop synchronizer on clk
//                 (reset value = slot 0); ready_out/level see a change after
//                 exactly two clk edges.
//     undefined : read_pointer is used directly (already synchronized outside).
//
// Ports
//   clk            in   1             write-domain clock
//   rstn           in   1             asynchronous active-low reset
//   data_in        in   DATA_WIDTH    upstream payload
//   valid_in       in   1             upstream valid
//   ready_out      out  1             upstream ready (not full)
//   write_pointer  out  BUFFER_DEPTH  one-hot write slot, also exported to read side
//   write_data     out  DATA_WIDTH    payload to dc_data_buffer (= data_in)
//   read_pointer   in   BUFFER_DEPTH  one-hot next-read slot from read domain
//   level          out  LEVEL_WIDTH   entries held, writer's (conservative) view
// -----------------------------------------------------------------------------
module dc_fifo_write_ctrl
   import dc_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH   = 32,
   parameter  int BUFFER_DEPTH = 8,
   localparam int LEVEL_WIDTH  = log2(BUFFER_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic [BUFFER_DEPTH-1:0] write_pointer,
   output logic [DATA_WIDTH-1:0]   write_data,
   input  logic [BUFFER_DEPTH-1:0] read_pointer,
   output logic [LEVEL_WIDTH-1:0]  level
);

   localparam logic [BUFFER_DEPTH-1:0] PTR_INIT  = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};
   localparam logic [LEVEL_WIDTH:0]    DEPTH_EXT = (LEVEL_WIDTH+1)'(BUFFER_DEPTH);

   logic [BUFFER_DEPTH-1:0] rp_int;
   logic [PTR_MAX-1:0]      wp_ext;
   logic [PTR_MAX-1:0]      rp_ext;
   logic [PTR_MAX-1:0]      wp_rot;
   logic                    full;
   logic                    accept;
   logic [LEVEL_WIDTH-1:0]  wp_bin;
   logic [LEVEL_WIDTH-1:0]  rp_bin;
   logic [LEVEL_WIDTH:0]    level_ext;
   logic                    unused_level_msb;

`ifdef DC_WR_SYNC_EN
   logic [BUFFER_DEPTH-1:0] rp_meta;
   logic [BUFFER_DEPTH-1:0] rp_sync;

   // Two-stage synchronizer for the read pointer coming from the read domain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rp_meta <= PTR_INIT;
         rp_sync <= PTR_INIT;
      end else begin
         rp_meta <= read_pointer;
         rp_sync <= rp_meta;
      end
   end

   assign rp_int = rp_sync;
`else
   assign rp_int = read_pointer;
`endif

   // The buffer writes the slot at write_pointer every cycle; that slot is not
   // yet visible to the reader, so passing data straight through is safe.
   assign write_data = data_in;

   // Zero-extend both pointers into the package's common ring width.
   always_comb begin
      wp_ext = '0;
      rp_ext = '0;
      wp_ext[BUFFER_DEPTH-1:0] = write_pointer;
      rp_ext[BUFFER_DEPTH-1:0] = rp_int;
   end

   assign wp_rot    = rotl1(wp_ext, BUFFER_DEPTH);
   assign full      = |(wp_rot & rp_ext);
   assign ready_out = ~full;
   assign accept    = valid_in & ready_out;

   // Pointer only ever rotates or reloads slot 0, so it stays one-hot even if
   // read_pointer is garbage (garbage can only stall it).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         write_pointer <= PTR_INIT;
      end else if (accept) begin
         write_pointer <= wp_rot[BUFFER_DEPTH-1:0];
      end else begin
         write_pointer <= write_pointer;
      end
   end

   dc_onehot_to_bin #(
      .WIDTH (BUFFER_DEPTH)
   ) u_wp_bin (
      .onehot (write_pointer),
      .bin    (wp_bin)
   );

   dc_onehot_to_bin #(
      .WIDTH (BUFFER_DEPTH)
   ) u_rp_bin (
      .onehot (rp_int),
      .bin    (rp_bin)
   );

   // Fill level = (wp - rp) mod BUFFER_DEPTH; the add-back handles wrap and
   // also covers depths that are not a power of two.
   always_comb begin
      level_ext = {1'b0, wp_bin} - {1'b0, rp_bin};
      if (wp_bin < rp_bin) begin
         level_ext = level_ext + DEPTH_EXT;
      end else begin
         level_ext = level_ext;
      end
   end

   assign level            = level_ext[LEVEL_WIDTH-1:0];
   assign unused_level_msb = level_ext[LEVEL_WIDTH];

endmodule
